// File: rtl/sd_read_block_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_read_block_pkg : shared SD SPI-mode opcodes, tokens, error codes  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sd_read_block_pkg;

    localparam logic [7:0] C_CMD17       = 8'h51;
    localparam logic [7:0] C_CMD24       = 8'h58;
    localparam logic [7:0] C_TOKEN_START = 8'hFE;

    localparam logic [1:0] C_ERR_NONE  = 2'd0;
    localparam logic [1:0] C_ERR_R1    = 2'd1;
    localparam logic [1:0] C_ERR_TOKEN = 2'd2;
    localparam logic [1:0] C_ERR_DATA  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SEND_CMD   = 3'd1,
        ST_WAIT_R1    = 3'd2,
        ST_WAIT_TOKEN = 3'd3,
        ST_READ_DATA  = 3'd4,
        ST_READ_CRC   = 3'd5,
        ST_FLUSH      = 3'd6,
        ST_DONE       = 3'd7
    } state_t;

    // A data-error token has its upper nibble clear.
    function automatic logic is_data_error_token(input logic [7:0] b);
        return (b[7:4] == 4'h0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_read_block_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_read_block_rx : posedge MISO byte deserialiser with start-bit     |
// | alignment; while hunting, each run of eight 1s reports as 0xFF.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sd_read_block_rx (
    input  logic       sd_ck,
    input  logic       rst_n,
    input  logic       sd_miso,
    input  logic       rearm,
    output logic [7:0] lane_byte,
    output logic       lane_end,
    output logic [7:0] rx_byte,
    output logic       rx_done
);

    logic [6:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_aligned;

    always_comb begin
        lane_byte = {r_shift, sd_miso};
        lane_end  = !rearm && (r_bit_cnt == 3'd7) && (r_aligned || sd_miso);
    end

    always_ff @(posedge sd_ck or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= 7'd0;
            r_bit_cnt <= 3'd0;
            r_aligned <= 1'b0;
            rx_byte   <= 8'd0;
            rx_done   <= 1'b0;
        end else if (rearm) begin
            r_shift   <= 7'd0;
            r_bit_cnt <= 3'd0;
            r_aligned <= 1'b0;
            rx_done   <= 1'b0;
        end else begin
            rx_done <= lane_end;
            if (lane_end) begin
                rx_byte <= lane_byte;
            end
            // First 0 while hunting is the MSB of R1 and fixes the byte framing.
            if (!r_aligned && !sd_miso) begin
                r_aligned <= 1'b1;
                r_bit_cnt <= 3'd1;
                r_shift   <= 7'd0;
            end else begin
                r_shift   <= {r_shift[5:0], sd_miso};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sd_read_block.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_read_block : SPI-mode SD single-block reader (CMD17)              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sd_read_block
    import sd_read_block_pkg::*;
#(
    parameter int         BLK_BYTES     = 512,
    parameter int         R1_TIMEOUT    = 64,
    parameter int         TOKEN_TIMEOUT = 4096,
    parameter logic [7:0] CMD17_CRC     = 8'hFF
) (
    input  logic        sd_ck,
    input  logic        rst_n,
    input  logic        sd_miso,
    output logic        sd_mosi,
    output logic        sd_csn,
    input  logic        init_o,
    input  logic        read_seq,
    input  logic [31:0] blk_addr,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        rd_last,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int CNT_W  = $clog2(TOKEN_TIMEOUT + 1);
    localparam int BCNT_W = $clog2(BLK_BYTES) + 1;

    localparam logic [CNT_W-1:0]  C_CMD_LOAD   = CNT_W'(48);
    localparam logic [CNT_W-1:0]  C_R1_LOAD    = CNT_W'(R1_TIMEOUT);
    localparam logic [CNT_W-1:0]  C_TOK_LOAD   = CNT_W'(TOKEN_TIMEOUT);
    localparam logic [CNT_W-1:0]  C_CRC_LOAD   = CNT_W'(2);
    localparam logic [CNT_W-1:0]  C_FLUSH_LOAD = CNT_W'(8);
    localparam logic [BCNT_W-1:0] C_LAST_BYTE  = BCNT_W'(BLK_BYTES - 1);

    state_t            r_state, w_state_nxt;
    logic [47:0]       r_cmd, w_cmd_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_dec;
    logic              w_cnt_last;
    logic [1:0]        r_pend, w_pend_nxt;
    logic              w_done_nxt, w_err_nxt;
    logic [1:0]        w_code_nxt;
    logic [BCNT_W-1:0] r_byte_cnt;

    logic       w_rearm, w_lane_end, w_rx_done, w_strobe;
    logic [7:0] w_lane_byte, w_rx_byte;

    sd_read_block_rx u_rx (
        .sd_ck     (sd_ck),
        .rst_n     (rst_n),
        .sd_miso   (sd_miso),
        .rearm     (w_rearm),
        .lane_byte (w_lane_byte),
        .lane_end  (w_lane_end),
        .rx_byte   (w_rx_byte),
        .rx_done   (w_rx_done)
    );

    always_comb begin
        w_rearm = !(r_state inside {ST_WAIT_R1, ST_WAIT_TOKEN, ST_READ_DATA, ST_READ_CRC});
        sd_csn  = !(r_state inside {ST_SEND_CMD, ST_WAIT_R1, ST_WAIT_TOKEN,
                                    ST_READ_DATA, ST_READ_CRC});
        sd_mosi = (r_state == ST_SEND_CMD) ? r_cmd[47] : 1'b1;
        busy    = (r_state != ST_IDLE) && (r_state != ST_DONE);
        w_strobe   = w_lane_end && (r_state == ST_READ_DATA);
        w_cnt_dec  = r_cnt - CNT_W'(|r_cnt);
        w_cnt_last = (r_cnt <= CNT_W'(1));
    end

    always_ff @(negedge sd_ck or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cmd    <= 48'd0;
            r_cnt    <= '0;
            r_pend   <= C_ERR_NONE;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= C_ERR_NONE;
        end else begin
            r_state  <= w_state_nxt;
            r_cmd    <= w_cmd_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pend   <= w_pend_nxt;
            done     <= w_done_nxt;
            err      <= w_err_nxt;
            err_code <= w_code_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_nxt   = r_cmd;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_done_nxt  = done;
        w_err_nxt   = err;
        w_code_nxt  = err_code;
        case (r_state)
            ST_IDLE: begin
                if (init_o && read_seq) begin
                    w_cmd_nxt   = {C_CMD17, blk_addr, CMD17_CRC};
                    w_cnt_nxt   = C_CMD_LOAD;
                    w_done_nxt  = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_code_nxt  = C_ERR_NONE;
                    w_state_nxt = ST_SEND_CMD;
                end
            end
            ST_SEND_CMD: begin
                w_cmd_nxt = {r_cmd[46:0], 1'b1};
                if (w_cnt_last) begin
                    w_cnt_nxt   = C_R1_LOAD;
                    w_state_nxt = ST_WAIT_R1;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            ST_WAIT_R1: begin
                if (w_rx_done) begin
                    if (w_rx_byte == 8'h00) begin
                        w_cnt_nxt   = C_TOK_LOAD;
                        w_state_nxt = ST_WAIT_TOKEN;
                    end else if (w_rx_byte == 8'hFF && !w_cnt_last) begin
                        w_cnt_nxt = w_cnt_dec;
                    end else begin
                        w_pend_nxt  = C_ERR_R1;
                        w_cnt_nxt   = C_FLUSH_LOAD;
                        w_state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_WAIT_TOKEN: begin
                if (w_rx_done) begin
                    if (w_rx_byte == C_TOKEN_START) begin
                        w_state_nxt = ST_READ_DATA;
                    end else if (is_data_error_token(w_rx_byte)) begin
                        w_pend_nxt  = C_ERR_DATA;
                        w_cnt_nxt   = C_FLUSH_LOAD;
                        w_state_nxt = ST_FLUSH;
                    end else if (w_cnt_last) begin
                        w_pend_nxt  = C_ERR_TOKEN;
                        w_cnt_nxt   = C_FLUSH_LOAD;
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_cnt_nxt = w_cnt_dec;
                    end
                end
            end
            ST_READ_DATA: begin
                // rd_last is registered on the same posedge that raises rx_done.
                if (w_rx_done && rd_last) begin
                    w_cnt_nxt   = C_CRC_LOAD;
                    w_state_nxt = ST_READ_CRC;
                end
            end
            ST_READ_CRC: begin
                if (w_rx_done) begin
                    if (w_cnt_last) begin
                        w_pend_nxt  = C_ERR_NONE;
                        w_cnt_nxt   = C_FLUSH_LOAD;
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_cnt_nxt = w_cnt_dec;
                    end
                end
            end
            ST_FLUSH: begin
                if (w_cnt_last) begin
                    if (r_pend == C_ERR_NONE) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_err_nxt  = 1'b1;
                        w_code_nxt = r_pend;
                    end
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            ST_DONE: begin
                if (!read_seq) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sd_ck or negedge rst_n) begin
        if (!rst_n) begin
            rd_data    <= 8'd0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            r_byte_cnt <= '0;
        end else begin
            rd_valid <= w_strobe;
            rd_last  <= w_strobe && (r_byte_cnt == C_LAST_BYTE);
            if (w_strobe) begin
                rd_data <= w_lane_byte;
                if (r_byte_cnt != C_LAST_BYTE) begin
                    r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
                end
            end
            if (r_state != ST_READ_DATA) begin
                r_byte_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire
